// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and constants for the nibble-serial adder.
// Holds the FSM state encoding and the index-width helper.
package nsa_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A single-nibble operand still needs a 1-bit index register.
    function automatic int idx_width(input int width);
        return (width / NIBBLE_W > 1) ? $clog2(width / NIBBLE_W) : 1;
    endfunction

endpackage

// File: rtl/nibble_serial_adder_nibble_add4.sv
// Purpose: 4-bit ripple-carry adder built from four chained full-adder cells.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; c3 exposes the carry into bit 3 for overflow detection.
module nibble_add4 (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co,
    output logic       c3
);

    logic [4:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < 4; i++) begin
            s[i]   = x[i] ^ y[i] ^ c[i];
            c[i+1] = (x[i] & y[i]) | (x[i] & c[i]) | (y[i] & c[i]);
        end
    end

    assign co = c[4];
    assign c3 = c[3];

endmodule

// File: rtl/nibble_serial_adder.sv
// Purpose: WIDTH-bit a+b+cin computed one nibble per clock; signed overflow output under NSA_OVF_EN.
// Latency: WIDTH/4 cycles from operand acceptance to out_valid; one operation in flight.
// Backpressure: result held in DONE until out_ready; in_ready stays low until the following cycle.
module nibble_serial_adder
    import nsa_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef NSA_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int N  = WIDTH / NIBBLE_W;
    localparam int IW = idx_width(WIDTH);
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_bad_width
        $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 4");
    end

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic [IW-1:0]    idx_q;

    logic [3:0]       nib_x;
    logic [3:0]       nib_y;
    logic [3:0]       nib_s;
    logic             nib_co;
    logic             nib_c3;

    assign nib_x = a_q[{idx_q, 2'b00} +: NIBBLE_W];
    assign nib_y = b_q[{idx_q, 2'b00} +: NIBBLE_W];

    nibble_add4 u_add4 (
        .x  (nib_x),
        .y  (nib_y),
        .ci (carry_q),
        .s  (nib_s),
        .co (nib_co),
        .c3 (nib_c3)
    );

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = RUN;
            end
            RUN: begin
                if (idx_q == LAST) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= cin;
                        idx_q   <= '0;
                        sum_q   <= '0;
                    end
                end
                RUN: begin
                    sum_q[{idx_q, 2'b00} +: NIBBLE_W] <= nib_s;
                    carry_q <= nib_co;
                    // Parking idx at LAST keeps the 1-bit index of WIDTH=4 from wrapping.
                    if (idx_q != LAST) idx_q <= idx_q + IW'(1);
                end
                default: ;
            endcase
        end
    end

    assign sum  = sum_q;
    assign cout = carry_q;

`ifdef NSA_OVF_EN
    logic ovf_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (state_q == RUN && idx_q == LAST) begin
            ovf_q <= nib_c3 ^ nib_co;
        end
    end

    assign ovf = ovf_q;
`else
    logic unused_c3;
    assign unused_c3 = nib_c3;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder (WIDTH=16): directed vectors plus back-to-back model-checked traffic.
module tb_nibble_serial_adder;

    localparam int WIDTH = 16;
    localparam int N     = WIDTH / 4;

    typedef struct {
        logic [15:0] s;
        logic        c;
        logic        o;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
`ifdef NSA_OVF_EN
    logic        ovf;
`endif

    nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef NSA_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t sb[$];
    int   accq[$];
    int   prev_acc  = 0;
    bit   have_prev = 1'b0;
    bit   ov_prev   = 1'b0;
    bit   hs_prev   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic send(input logic [15:0] ta, input logic [15:0] tb_, input logic tc,
                        input logic [15:0] es, input logic ec, input logic eo);
        int   g;
        exp_t e;
        g = 0;
        @(negedge clk);
        a = ta; b = tb_; cin = tc; in_valid = 1'b1;
        while (in_ready !== 1'b1 && g < 40) begin
            @(negedge clk);
            g++;
        end
        if (in_ready !== 1'b1) begin
            check("accept_timeout", {31'd0, in_ready}, 32'd1);
        end else begin
            if (have_prev) check("issue_spacing", {31'd0, (cyc - prev_acc) >= N + 2}, 32'd1);
            e.s = es; e.c = ec; e.o = eo;
            sb.push_back(e);
            accq.push_back(cyc + 1);
            prev_acc  = cyc;
            have_prev = 1'b1;
            @(posedge clk);
        end
    endtask

    task automatic drain();
        int g;
        g = 0;
        @(negedge clk);
        in_valid = 1'b0;
        while (sb.size() != 0 && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
    endtask

    // Monitor: every valid cycle is checked against the scoreboard head; pops on handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            ov_prev = 1'b0;
            hs_prev = 1'b0;
        end else begin
            if (hs_prev) begin
                check("in_ready_after_hs", {31'd0, in_ready}, 32'd1);
                check("out_valid_after_hs", {31'd0, out_valid}, 32'd0);
            end
            hs_prev = 1'b0;
            if (out_valid === 1'b1) begin
                check("in_ready_low_in_done", {31'd0, in_ready}, 32'd0);
                if (sb.size() == 0) begin
                    check("unexpected_output", 32'd0, 32'd1);
                end else begin
                    if (!ov_prev && accq.size() != 0) check("latency", cyc - accq.pop_front(), N);
                    check("sum", {16'd0, sum}, {16'd0, sb[0].s});
                    check("cout", {31'd0, cout}, {31'd0, sb[0].c});
`ifdef NSA_OVF_EN
                    check("ovf", {31'd0, ovf}, {31'd0, sb[0].o});
`endif
                    if (out_ready === 1'b1) begin
                        void'(sb.pop_front());
                        hs_prev = 1'b1;
                    end
                end
            end
            ov_prev = (out_valid === 1'b1);
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rc;
        logic [16:0] full;
        logic        ro;
        int          g;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_sum", {16'd0, sum}, 32'd0);
        check("rst_cout", {31'd0, cout}, 32'd0);
`ifdef NSA_OVF_EN
        check("rst_ovf", {31'd0, ovf}, 32'd0);
`endif
        @(posedge clk); #1 rst_n = 1'b1;

        // Directed vectors: a, b, cin -> sum, cout, ovf
        send(16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0); drain();
        send(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0); drain();
        send(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1); drain();
        send(16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0); drain();
        send(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1); drain();
        send(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0); drain();
        send(16'h00FF, 16'h0F01, 1'b0, 16'h1000, 1'b0, 1'b0); drain();
        send(16'hABCD, 16'h1111, 1'b1, 16'hBCDF, 1'b0, 1'b0); drain();

        // Backpressure: result must sit unchanged while out_ready is low
        @(posedge clk); #1 out_ready = 1'b0;
        send(16'h5555, 16'hAAAA, 1'b1, 16'h0000, 1'b1, 1'b0);
        g = 0;
        while (out_valid !== 1'b1 && g < 20) begin
            @(negedge clk);
            g++;
        end
        check("bp_out_valid_seen", {31'd0, out_valid}, 32'd1);
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
        drain();

        // Reset during the second RUN cycle discards the operation
        have_prev = 1'b0;
        send(16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0);
        @(posedge clk); #1 rst_n = 1'b0; in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_sum", {16'd0, sum}, 32'd0);
        check("midrst_cout", {31'd0, cout}, 32'd0);
        sb.delete();
        accq.delete();
        have_prev = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        send(16'h4321, 16'h1234, 1'b0, 16'h5555, 1'b0, 1'b0); drain();

        // Back-to-back traffic with in_valid held high, checked against a+b+cin
        have_prev = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            ra   = 16'($urandom);
            rb   = 16'($urandom);
            rc   = 1'($urandom);
            full = {1'b0, ra} + {1'b0, rb} + {16'd0, rc};
            ro   = (ra[15] == rb[15]) && (full[15] != ra[15]);
            send(ra, rb, rc, full[15:0], full[16], ro);
        end
        drain();

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
